// File: rtl/pw_tx_pkg.sv
// pw_tx_pkg: shared types and constants for the UTMI transmit engine.
// Optional CRC generation is enabled with the PW_TX_CRC16_EN macro.
package pw_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_BUS,
    SEND,
    CRC_LO,
    CRC_HI,
    DONE,
    ABORT
  } tx_state_e;

  // USB CRC16, LSB-first (reflected) form.
  localparam logic [15:0] CRC16_POLY_R   = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  // One byte through the reflected CRC16 LFSR, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {8'h00, d};
    for (int i = 0; i < 8; i++)
      c = c[0] ? ((c >> 1) ^ CRC16_POLY_R) : (c >> 1);
    return c;
  endfunction

endpackage

// File: rtl/pw_utmi_tx_if.sv
// pw_utmi_tx_if: host write/go side plus the UTMI transmit pins of pw_utmi_tx.
// master = host/PHY model side, slave = the transmit engine.
interface pw_utmi_tx_if #(parameter int CW = 7);
  logic [7:0]    I_wr_data;
  logic          I_wr_en;
  logic          I_clear;
  logic          I_go;
  logic          I_fe_rxactive;
  logic          I_fe_txrdy;
  logic [7:0]    O_fe_data;
  logic          O_fe_txvalid;
  logic          O_fe_drive;
  logic          O_busy;
  logic          O_done;
  logic          O_abort;
  logic [CW-1:0] O_count;
  logic          O_wr_err;

  modport master (
    output I_wr_data, I_wr_en, I_clear, I_go, I_fe_rxactive, I_fe_txrdy,
    input  O_fe_data, O_fe_txvalid, O_fe_drive, O_busy, O_done, O_abort, O_count, O_wr_err
  );

  modport slave (
    input  I_wr_data, I_wr_en, I_clear, I_go, I_fe_rxactive, I_fe_txrdy,
    output O_fe_data, O_fe_txvalid, O_fe_drive, O_busy, O_done, O_abort, O_count, O_wr_err
  );
endinterface

// File: rtl/pw_usb_crc16.sv
// pw_usb_crc16: byte-wide USB CRC16 next-state, purely combinational.
// Only compiled into the design when PW_TX_CRC16_EN is defined.
`ifdef PW_TX_CRC16_EN
module pw_usb_crc16
  import pw_tx_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data,
  input  logic        init,
  input  logic        en,
  output logic [15:0] crc_out
);

  // init has priority so the register is seeded before the first payload byte
  always_comb begin
    crc_out = crc_in;
    if (init)    crc_out = CRC16_INIT;
    else if (en) crc_out = crc16_byte(crc_in, data);
  end

endmodule
`endif

// File: rtl/pw_utmi_tx.sv
// pw_utmi_tx: UTMI transmit engine. Host fills a byte buffer (PID first),
// a go pulse waits for pTURNAROUND quiet bus cycles, then the buffer is
// streamed over TxValid/TxReady. Define PW_TX_CRC16_EN to append the
// inverted USB CRC16 (low byte first) over buf[1..count-1].
module pw_utmi_tx
  import pw_tx_pkg::*;
#(
  parameter int pBUF_DEPTH  = 64,
  parameter int pTURNAROUND = 4,
  parameter int pTX_TIMEOUT = 255
) (
  input  logic         fe_clk,
  input  logic         reset_n,
  pw_utmi_tx_if.slave  tx
);

  localparam int AW = $clog2(pBUF_DEPTH);
  localparam int CW = AW + 1;
  localparam int QW = $clog2(pTURNAROUND + 1);
  localparam int TW = $clog2(pTX_TIMEOUT + 1);

  tx_state_e     state, state_nxt;
  logic [7:0]    mem [pBUF_DEPTH];
  logic [CW-1:0] count;
  logic          wr_err;
  logic [AW-1:0] idx, idx_nxt;
  logic [QW-1:0] qcnt;
  logic [TW-1:0] wcnt;
  logic [7:0]    data_q, data_nxt;

  logic idle, tx_phase, rdy, last, timeout, wr_ok;

  assign idle     = (state == IDLE);
  assign tx_phase = (state == SEND) || (state == CRC_LO) || (state == CRC_HI);
  // TxReady only means something while TxValid is up
  assign rdy      = tx_phase && tx.I_fe_txrdy;
  assign last     = ({1'b0, idx} == (count - CW'(1)));
  assign timeout  = tx_phase && !tx.I_fe_txrdy && (wcnt == TW'(pTX_TIMEOUT - 1));
  assign wr_ok    = idle && tx.I_wr_en && !tx.I_clear && (count != CW'(pBUF_DEPTH));

`ifdef PW_TX_CRC16_EN
  logic [15:0] crc_q, crc_nxt;

  pw_usb_crc16 u_crc (
    .crc_in  (crc_q),
    .data    (data_q),
    .init    (state == WAIT_BUS),
    .en      ((state == SEND) && rdy && (idx != '0)),
    .crc_out (crc_nxt)
  );

  // running CRC; reseeded every cycle spent waiting for the bus
  always_ff @(posedge fe_clk) begin
    if (!reset_n) crc_q <= CRC16_INIT;
    else          crc_q <= crc_nxt;
  end
`endif

  // state register
  always_ff @(posedge fe_clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state: bus wait, byte handshake, timeout
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:     if (tx.I_go && (count != '0)) state_nxt = WAIT_BUS;
      WAIT_BUS: if (!tx.I_fe_rxactive && (qcnt == QW'(pTURNAROUND - 1))) state_nxt = SEND;
      SEND: begin
        if (rdy && last)
`ifdef PW_TX_CRC16_EN
          state_nxt = CRC_LO;
`else
          state_nxt = DONE;
`endif
        else if (timeout) state_nxt = ABORT;
      end
`ifdef PW_TX_CRC16_EN
      CRC_LO: if (rdy) state_nxt = CRC_HI; else if (timeout) state_nxt = ABORT;
      CRC_HI: if (rdy) state_nxt = DONE;   else if (timeout) state_nxt = ABORT;
`endif
      DONE:     state_nxt = IDLE;
      ABORT:    state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // byte index and the registered byte presented to the PHY next cycle
  always_comb begin
    idx_nxt = idx;
    if (state == WAIT_BUS)                  idx_nxt = '0;
    else if ((state == SEND) && rdy && !last) idx_nxt = idx + AW'(1);
    data_nxt = '0;
    case (state_nxt)
      SEND:    data_nxt = mem[idx_nxt];
`ifdef PW_TX_CRC16_EN
      CRC_LO:  data_nxt = ~crc_nxt[7:0];
      CRC_HI:  data_nxt = ~crc_q[15:8];
`endif
      default: data_nxt = '0;
    endcase
  end

  // quiet-bus counter, per-byte TxReady wait counter, data register
  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      idx    <= '0;
      qcnt   <= '0;
      wcnt   <= '0;
      data_q <= '0;
    end else begin
      idx    <= idx_nxt;
      data_q <= data_nxt;
      qcnt   <= ((state != WAIT_BUS) || tx.I_fe_rxactive) ? '0 : qcnt + QW'(1);
      wcnt   <= (!tx_phase || tx.I_fe_txrdy) ? '0 : wcnt + TW'(1);
    end
  end

  // fill level and sticky dropped-write flag; clear beats write
  always_ff @(posedge fe_clk) begin
    if (!reset_n) begin
      count  <= '0;
      wr_err <= 1'b0;
    end else if (idle && tx.I_clear) begin
      count  <= '0;
      wr_err <= 1'b0;
    end else if (tx.I_wr_en) begin
      if (wr_ok) count  <= count + CW'(1);
      else       wr_err <= 1'b1;
    end
  end

  // packet RAM write port, no reset so it maps to distributed RAM
  always_ff @(posedge fe_clk) begin
    if (wr_ok) mem[count[AW-1:0]] <= tx.I_wr_data;
  end

  assign tx.O_fe_data    = data_q;
  assign tx.O_fe_txvalid = tx_phase;
  assign tx.O_fe_drive   = tx_phase;
  assign tx.O_busy       = !idle;
  assign tx.O_done       = (state == DONE);
  assign tx.O_abort      = (state == ABORT);
  assign tx.O_count      = count;
  assign tx.O_wr_err     = wr_err;

endmodule

// File: tb/tb_pw_utmi_tx.sv
// tb_pw_utmi_tx: directed vector table plus hand sequences for pw_utmi_tx
// (depth 64, turnaround 4, TxReady timeout 8). CRC cases need PW_TX_CRC16_EN.
module tb_pw_utmi_tx;
  import pw_tx_pkg::*;

  logic fe_clk  = 1'b0;
  logic reset_n = 1'b0;
  int   checks  = 0;
  int   errors  = 0;
  logic [7:0] cap [$];

  always #5 fe_clk = ~fe_clk;

  pw_utmi_tx_if #(.CW(7)) bus ();

  pw_utmi_tx #(.pBUF_DEPTH(64), .pTURNAROUND(4), .pTX_TIMEOUT(8)) dut (
    .fe_clk  (fe_clk),
    .reset_n (reset_n),
    .tx      (bus)
  );

  typedef struct {
    logic        we;
    logic [7:0]  wd;
    logic        clr, go, rx, rdy;
    logic [20:0] exp;
  } vec_t;

  vec_t vt [20];

  function automatic logic [20:0] ev(logic txv, logic busy, logic done, logic abrt,
                                     logic werr, logic [7:0] d, logic [6:0] cnt);
    return {txv, txv, busy, done, abrt, werr, d, cnt};
  endfunction

  function automatic vec_t mkv(logic we, logic [7:0] wd, logic clr, logic go,
                               logic rx, logic rdy, logic [20:0] e);
    vec_t v;
    v.we = we; v.wd = wd; v.clr = clr; v.go = go; v.rx = rx; v.rdy = rdy; v.exp = e;
    return v;
  endfunction

  function automatic logic [20:0] outs();
    return {bus.O_fe_txvalid, bus.O_fe_drive, bus.O_busy, bus.O_done, bus.O_abort,
            bus.O_wr_err, bus.O_fe_data, bus.O_count};
  endfunction

  // bit-serial reference CRC, LSB first
  function automatic logic [15:0] crc_model(logic [15:0] c, logic [7:0] d);
    logic fb;
    for (int b = 0; b < 8; b++) begin
      fb = c[0] ^ d[b];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic set_in(logic we, logic [7:0] wd, logic clr, logic go, logic rx, logic rdy);
    bus.I_wr_en = we; bus.I_wr_data = wd; bus.I_clear = clr;
    bus.I_go = go; bus.I_fe_rxactive = rx; bus.I_fe_txrdy = rdy;
  endtask

  task automatic clear_buf();
    bus.I_clear = 1'b1; tick(); bus.I_clear = 1'b0;
  endtask

  task automatic wr_byte(input logic [7:0] b);
    bus.I_wr_en = 1'b1; bus.I_wr_data = b; tick(); bus.I_wr_en = 1'b0;
  endtask

  task automatic go();
    bus.I_go = 1'b1; tick(); bus.I_go = 1'b0;
  endtask

  task automatic load5();
    clear_buf();
    wr_byte(8'hC3); wr_byte(8'h00); wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
  endtask

  // drive TxReady (mode 0: always 1, mode 1: 0/1 alternating), capture accepted
  // bytes, check data holds during stalls; bounded so a hang becomes a FAIL
  task automatic send_collect(input int mode, output bit done_seen);
    logic [7:0] prev;
    bit stall;
    prev = '0; stall = 0; done_seen = 0;
    cap.delete();
    for (int c = 0; c < 200; c++) begin
      bus.I_fe_txrdy = (mode == 0) ? 1'b1 : c[0];
      if (stall) chk("hold_data", bus.O_fe_data, prev);
      stall = bus.O_fe_txvalid && !bus.I_fe_txrdy;
      prev  = bus.O_fe_data;
      if (bus.O_fe_txvalid && bus.I_fe_txrdy) cap.push_back(bus.O_fe_data);
      if (bus.O_done) begin done_seen = 1; break; end
      tick();
    end
    bus.I_fe_txrdy = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit dn;
    logic [7:0] exp5 [5];
    exp5[0] = 8'hC3; exp5[1] = 8'h00; exp5[2] = 8'h01; exp5[3] = 8'h02; exp5[4] = 8'h03;

    // --- vector table: load, send with TxReady=1, write-while-busy, clear, empty go
    vt[0]  = mkv(0, 8'h00, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 8'h00, 0));
    vt[1]  = mkv(1, 8'hC3, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 8'h00, 1));
    vt[2]  = mkv(1, 8'h00, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 8'h00, 2));
    vt[3]  = mkv(1, 8'h01, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 8'h00, 3));
    vt[4]  = mkv(1, 8'h02, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 8'h00, 4));
    vt[5]  = mkv(1, 8'h03, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 8'h00, 5));
    vt[6]  = mkv(0, 8'h00, 0, 1, 0, 0, ev(0, 1, 0, 0, 0, 8'h00, 5));
    vt[7]  = mkv(0, 8'h00, 0, 0, 0, 0, ev(0, 1, 0, 0, 0, 8'h00, 5));
    vt[8]  = mkv(1, 8'h55, 0, 0, 0, 0, ev(0, 1, 0, 0, 1, 8'h00, 5));
    vt[9]  = mkv(0, 8'h00, 0, 0, 0, 0, ev(0, 1, 0, 0, 1, 8'h00, 5));
    vt[10] = mkv(0, 8'h00, 0, 0, 0, 1, ev(1, 1, 0, 0, 1, 8'hC3, 5));
    vt[11] = mkv(0, 8'h00, 0, 0, 0, 1, ev(1, 1, 0, 0, 1, 8'h00, 5));
    vt[12] = mkv(0, 8'h00, 0, 0, 0, 1, ev(1, 1, 0, 0, 1, 8'h01, 5));
    vt[13] = mkv(0, 8'h00, 0, 0, 0, 1, ev(1, 1, 0, 0, 1, 8'h02, 5));
    vt[14] = mkv(0, 8'h00, 0, 0, 0, 1, ev(1, 1, 0, 0, 1, 8'h03, 5));
    vt[15] = mkv(0, 8'h00, 0, 0, 0, 1, ev(0, 1, 1, 0, 1, 8'h00, 5));
    vt[16] = mkv(0, 8'h00, 0, 0, 0, 0, ev(0, 0, 0, 0, 1, 8'h00, 5));
    vt[17] = mkv(1, 8'hAA, 1, 0, 0, 0, ev(0, 0, 0, 0, 0, 8'h00, 0));
    vt[18] = mkv(0, 8'h00, 0, 1, 0, 0, ev(0, 0, 0, 0, 0, 8'h00, 0));
    vt[19] = mkv(0, 8'h00, 0, 0, 0, 0, ev(0, 0, 0, 0, 0, 8'h00, 0));

    set_in(0, 8'h00, 0, 0, 0, 0);
    tick(); tick();
    chk("reset_outputs", 32'(outs()), 32'(0));
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      set_in(vt[i].we, vt[i].wd, vt[i].clr, vt[i].go, vt[i].rx, vt[i].rdy);
      tick();
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
    end
    set_in(0, 8'h00, 0, 0, 0, 0);

    // --- alternating TxReady: each byte held, 5 accepted in order
    load5();
    go();
    send_collect(1, dn);
    chk("alt_done", 32'(dn), 32'(1));
    chk("alt_nbytes", cap.size(), 5);
    for (int i = 0; i < 5 && i < cap.size(); i++)
      chk($sformatf("alt_byte%0d", i), 32'(cap[i]), 32'(exp5[i]));
    tick();

    // --- rxactive holds off TX; a re-pulse restarts the quiet count
    bus.I_fe_rxactive = 1'b1;
    go();
    for (int i = 0; i < 7; i++) tick();
    chk("rx_hold_txvalid", 32'(bus.O_fe_txvalid), 32'(0));
    bus.I_fe_rxactive = 1'b0; tick(); tick();
    bus.I_fe_rxactive = 1'b1; tick();
    bus.I_fe_rxactive = 1'b0;
    tick(); tick(); tick();
    chk("rx_quiet3_txvalid", 32'(bus.O_fe_txvalid), 32'(0));
    tick();
    chk("rx_quiet4_txvalid", 32'(bus.O_fe_txvalid), 32'(1));
    send_collect(0, dn);
    chk("rx_done", 32'(dn), 32'(1));
    chk("rx_nbytes", cap.size(), 5);
    tick();

    // --- TxReady stuck low: abort 8 cycles after TxValid rises (buffer resent)
    go();
    tick(); tick(); tick(); tick();
    chk("to_txvalid_rise", 32'(bus.O_fe_txvalid), 32'(1));
    for (int i = 0; i < 7; i++) tick();
    chk("to_pre_abort", {bus.O_abort, bus.O_fe_txvalid}, 32'(2'b01));
    tick();
    chk("to_abort", {bus.O_abort, bus.O_fe_txvalid, bus.O_done}, 32'(3'b100));
    tick();
    chk("to_after", {bus.O_abort, bus.O_busy, 7'(bus.O_count)}, 32'({1'b0, 1'b0, 7'd5}));

    // --- reset mid-SEND: everything back to zero on the next edge
    go();
    tick(); tick(); tick(); tick();
    bus.I_fe_txrdy = 1'b1; tick(); tick();
    chk("rst_mid_txvalid", {bus.O_fe_txvalid, bus.O_fe_data}, 32'({1'b1, 8'h01}));
    reset_n = 1'b0; tick();
    chk("rst_mid_outputs", 32'(outs()), 32'(0));
    reset_n = 1'b1; bus.I_fe_txrdy = 1'b0; tick();

    // --- overflow: 65 writes into 64 entries, then empty go does nothing
    clear_buf();
    for (int i = 0; i < 65; i++) wr_byte(8'(i));
    chk("full_count", 32'(bus.O_count), 32'(64));
    chk("full_wr_err", 32'(bus.O_wr_err), 32'(1));
    clear_buf();
    chk("clear_state", {bus.O_wr_err, bus.O_count}, 32'(0));
    begin
      bit act;
      act = 0;
      go();
      for (int i = 0; i < 10; i++) begin
        if (bus.O_fe_txvalid || bus.O_done || bus.O_busy) act = 1;
        tick();
      end
      chk("empty_go_quiet", 32'(act), 32'(0));
    end

`ifdef PW_TX_CRC16_EN
    // --- CRC: PID-only packet, then random payloads against the residual
    clear_buf();
    wr_byte(8'hC3);
    go();
    send_collect(0, dn);
    chk("crc_pid_done", 32'(dn), 32'(1));
    chk("crc_pid_nbytes", cap.size(), 3);
    if (cap.size() == 3)
      chk("crc_pid_bytes", {cap[0], cap[1], cap[2]}, 32'(24'hC30000));
    tick();
    for (int p = 0; p < 4; p++) begin
      int n;
      logic [7:0] pl [$];
      logic [15:0] c;
      n = $urandom_range(1, 20);
      pl.delete();
      clear_buf();
      wr_byte(8'h4B);
      for (int i = 0; i < n; i++) begin
        pl.push_back(8'($urandom));
        wr_byte(pl[i]);
      end
      go();
      send_collect(0, dn);
      chk($sformatf("crc_rnd%0d_nbytes", p), cap.size(), n + 3);
      if (cap.size() == n + 3) begin
        bit same;
        same = (cap[0] == 8'h4B);
        for (int i = 0; i < n; i++) if (cap[i+1] != pl[i]) same = 0;
        chk($sformatf("crc_rnd%0d_payload", p), 32'(same), 32'(1));
        c = 16'hFFFF;
        for (int i = 1; i < n + 3; i++) c = crc_model(c, cap[i]);
        chk($sformatf("crc_rnd%0d_residual", p), 32'(c), 32'(16'hB001));
      end
      tick();
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
